// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller.
//   - op encodings driven on mdu_ctrl.op
//   - FSM state type used by mdu_ctrl
//   - default iteration count per operation
//   - abs32: two's-complement magnitude of a 32-bit value
package mdu_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // The magnitude of 32'h80000000 is itself, which is the correct unsigned
  // magnitude once the datapath treats the value as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned multiply / restoring divide datapath.
// Purely combinational; mdu_ctrl holds the accumulators.
//   is_div  : 0 = shift-add multiply step, 1 = restoring subtract-shift step
//   a       : multiplicand (multiply) or divisor (divide)
//   hi_in   : partial product high word (multiply) or partial remainder (divide)
//   lo_in   : remaining multiplier bits (multiply) or dividend/quotient (divide)
//   hi_out / lo_out : accumulator values after this step
module mdu_step (
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, a} : 33'd0);
    shifted = {hi_in, lo_in[31]};
    ge      = (shifted >= {1'b0, a});
    // When ge holds, the true difference is below the divisor and so fits in
    // 32 bits; the modulo-2^32 subtraction is exact.
    diff    = shifted[31:0] - a;

    if (is_div) begin
      hi_out = ge ? diff : shifted[31:0];
      lo_out = {lo_in[30:0], ge};
    end else begin
      // {sum, lo_in} shifted right by one: the product bits retire into lo.
      hi_out = sum[32:1];
      lo_out = {sum[0], lo_in[31:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: iterative MULT/MULTU/DIV/DIVU with
// architectural HI/LO registers, MTHI/MTLO writes and flush abort.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start, op         : begin an operation (sampled in IDLE only), op select
//   rs_val, rt_val    : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata : direct HI/LO writes in IDLE
//   flush             : abort an in-flight operation
//   busy, done        : not-IDLE indicator, one-cycle completion pulse
//   hi, lo            : HI/LO contents
//
// state | meaning
// IDLE  | waiting for start; accepts mthi/mtlo writes
// CALC  | one datapath step per cycle, ITER cycles, commits HI/LO on the last
// DONE  | done pulse with the new HI/LO visible, then back to IDLE
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      acc_hi_q, acc_hi_d;
  logic [31:0]      acc_lo_q, acc_lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_main_q, neg_main_d;
  logic             neg_rem_q, neg_rem_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] step_hi, step_lo;

  mdu_step u_step (
    .is_div (is_div_q),
    .a      (a_q),
    .hi_in  (acc_hi_q),
    .lo_in  (acc_lo_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Operand preparation for a new operation.
  logic        op_signed, op_div, rs_neg, rt_neg, div_zero;
  logic [31:0] rs_abs, rt_abs;

  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    rs_neg    = op_signed & rs_val[31];
    rt_neg    = op_signed & rt_val[31];
    rs_abs    = rs_neg ? abs32(rs_val) : rs_val;
    rt_abs    = rt_neg ? abs32(rt_val) : rt_val;
    div_zero  = op_div & (rt_val == 32'd0);
  end

  // Sign fixup on the final step's result.
  logic [63:0] prod, prod_fix;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_main_q ? (~prod + 64'd1) : prod;
    if (is_div_q) begin
      fix_lo = neg_main_q ? (~step_lo + 32'd1) : step_lo;
      fix_hi = neg_rem_q  ? (~step_hi + 32'd1) : step_hi;
    end else begin
      fix_lo = prod_fix[31:0];
      fix_hi = prod_fix[63:32];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A start in IDLE always drops coincident mthi/mtlo writes.
          if (!flush) begin
            state_d  = ST_CALC;
            cnt_d    = '0;
            is_div_d = op_div;
            acc_hi_d = 32'd0;
            if (op_div) begin
              a_d = rt_abs;
              // Divide by zero runs the raw dividend through: the restoring
              // steps then yield an all-ones quotient and rs_val as remainder.
              acc_lo_d = div_zero ? rs_val : rs_abs;
            end else begin
              a_d      = rs_abs;
              acc_lo_d = rt_abs;
            end
            neg_main_d = (rs_neg ^ rt_neg) & ~div_zero;
            neg_rem_d  = rs_neg & op_div & ~div_zero;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= 32'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed scenarios plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl #(.ITER(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Architectural result of an operation, from plain integer arithmetic.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin eh = a % b; el = a / b; end
      end
    endcase
  endtask

  task automatic idle_inputs();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  // Full operation with latency checks. noisy drives junk on start/op/
  // operands/mthi/mtlo while busy; flush_done pulses flush in the DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit noisy, input bit flush_done);
    int bad_busy, bad_done;
    bad_busy = 0; bad_done = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);  // between edge E_k and E_k+1
      if (k == 0) start = 1'b0;
      if (noisy && k <= 32) begin
        start  = 1'($urandom_range(0, 1));
        op     = 2'($urandom_range(0, 3));
        rs_val = $urandom;
        rt_val = $urandom;
        mthi   = 1'($urandom_range(0, 1));
        mtlo   = 1'($urandom_range(0, 1));
        wdata  = $urandom;
      end
      if (flush_done && k == 32) flush = 1'b1;
      if (k == 33) idle_inputs();
      if (busy !== (k <= 32)) bad_busy++;
      if (done !== (k == 32)) bad_done++;
      if (k == 32) begin
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
      end
    end
    chk({tag, "_busy_pattern"}, 64'(bad_busy), 64'd0);
    chk({tag, "_done_pattern"}, 64'(bad_done), 64'd0);
    m_hi = eh; m_lo = el;
    chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
  endtask

  // Start then flush on CALC cycle number at+1; with_mt adds a dropped mtlo.
  task automatic flush_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int at, input bit with_mt);
    int bad_done;
    bad_done = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (with_mt) begin mtlo = 1'b1; mthi = 1'b1; wdata = $urandom; end
    for (int k = 0; k <= at + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
      if (done !== 1'b0) bad_done++;
      if (k == at) flush = 1'b1;
      if (k == at + 1) begin
        flush = 1'b0;
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
      end
    end
    chk({tag, "_no_done"}, 64'(bad_done), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] eh, el, a, b;
    logic [1:0]  o;

    reset_n = 1'b0;
    idle_inputs();
    op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; wdata = 32'd0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[4] = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;

    mt_write(1'b1, 1'b0, 32'hA5A5_0001);
    mt_write(1'b0, 1'b1, 32'h5A5A_0002);
    mt_write(1'b1, 1'b1, 32'hC0DE_0003);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("dir%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, (i % 2) == 1, 1'b0);

    // Flush on the 10th CALC cycle after MTHI.
    mt_write(1'b1, 1'b0, 32'h1234_5678);
    flush_op("flush_mult", 2'b00, 32'h0000_1234, 32'hFFFF_0001, 9, 1'b0);
    chk("flush_hi_kept", {32'd0, hi}, 64'h0000_0000_1234_5678);

    // start with coincident mthi/mtlo: writes dropped, then abort.
    flush_op("start_mt", 2'b11, $urandom, $urandom, 3, 1'b1);

    // start with flush in IDLE never begins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01;
    @(negedge clk);
    idle_inputs();
    chk("start_flush_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("start_flush_busy2", {63'd0, busy}, 64'd0);

    // flush during DONE keeps the committed result.
    ref_op(2'b00, 32'h8000_0000, 32'h8000_0000, eh, el);
    run_op("flush_done", 2'b00, 32'h8000_0000, 32'h8000_0000, eh, el, 1'b0, 1'b1);

    // Reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", {63'd0, busy}, 64'd0);
    ref_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, eh, el);
    run_op("after_rst", 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, eh, el, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      ref_op(o, a, b, eh, el);
      run_op($sformatf("rnd%0d", i), o, a, b, eh, el, (i % 3) == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: ITER, default 32, meaning the number of iteration cycles per multiply or divide operation.
REQ-002 Port: clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-004 Port: start, in, 1, request to begin an operation; sampled only in IDLE.
REQ-005 Port: op, in, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: rs_val / rt_val, in, 32 each, multiplicand/dividend and multiplier/divisor.
REQ-007 Port: mthi / mtlo, in, 1 each, direct write of wdata into HI / LO.
REQ-008 Port: wdata, in, 32, data for mthi/mtlo.
REQ-009 Port: flush, in, 1, abort request from exception/interrupt logic.
REQ-010 Port: busy, out, 1, high whenever state != IDLE; the pipeline stalls MFHI/MFLO/MDU ops on it.
REQ-011 Port: done, out, 1, one-cycle completion pulse.
REQ-012 Port: hi / lo, out, 32 each, architectural HI/LO register contents.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE: start=1 and flush=0 SHALL latch the operands (absolute values for signed ops), the op code and the sign flags, clear the counter, and move to CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle and increment the counter.
REQ-016 The CALC edge with counter == ITER-1 SHALL apply sign fixup, write HI/LO and move to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, with hi/lo already holding the new result, then return to IDLE.
REQ-018 Latency: with start sampled at edge E0, HI/LO SHALL update at edge E32, done SHALL be high between E32 and E33, and busy SHALL be high from E0 to E33 (33 cycles).
REQ-019 Multiply SHALL produce the 64-bit product {HI,LO}; signed product SHALL be negated (two's complement, 64-bit) when operand signs differ.
REQ-020 Divide SHALL produce LO=quotient and HI=remainder; signed quotient SHALL be negated when signs differ, and the remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero (either signedness) SHALL take the full latency, with LO=32'hFFFFFFFF, HI=rs_val and no fixup.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-023 mthi/mtlo SHALL write only in IDLE; they SHALL be ignored while busy.
REQ-024 mthi and mtlo asserted in the same cycle SHALL both write.
REQ-025 If start and mthi/mtlo coincide in IDLE, start SHALL win and the writes SHALL be dropped.
REQ-026 flush in CALC SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged and suppress done.
REQ-027 flush in DONE SHALL NOT undo the already-committed HI/LO.
REQ-028 flush coincident with start in IDLE SHALL suppress the start.
REQ-029 start, op and operand changes while busy SHALL be ignored.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE, counter=0, busy=0, done=0, hi=0 and lo=0, including mid-operation; operation SHALL resume normally from the first edge after deassertion.

Structure
REQ-031 A shared package mdu_pkg SHALL hold the op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), the FSM state typedef and the ITER default.
REQ-032 One combinational sub-module, mdu_step, SHALL implement a single multiply/divide iteration; mdu_ctrl SHALL own all registers and the FSM.

Verification
REQ-033 Scenario 1: MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001; done exactly at E32-E33; busy for 33 cycles.
REQ-034 Scenario 2: MULT FFFFFFFD x 00000007 -> HI=FFFFFFFF, LO=FFFFFFEB.
REQ-035 Scenario 3: DIV FFFFFFF9 / 00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 100 / 7 -> LO=0000000E, HI=00000002.
REQ-036 Scenario 4: DIVU 5 / 0 -> LO=FFFFFFFF, HI=00000005; DIV 80000000 / FFFFFFFF -> LO=80000000, HI=00000000.
REQ-037 Scenario 5: flush on the 10th CALC cycle of a MULT following MTHI 12345678 -> busy low after the next edge, no done pulse, HI=12345678 retained.
REQ-038 Scenario 6: reset_n low mid-CALC -> busy, done, hi and lo all 0 immediately; mthi while busy -> HI unchanged at completion except by the result.
